tsmp_command_assemble: RTL and testbench

- Sits directly upstream of the configuration command parser in the TSNNIC 4-port datapath.
- Takes the NMAC configuration payload of a decapsulated TSMP frame as an 8-bit byte stream.
- Assembles fixed 26-byte commands into 204-bit command words.
- Steers each word to the write-command port or the read-command port by its type field, and keeps saturating statistics on good, dropped and malformed commands.

---
 rtl/tsn_cfg_pkg.sv | 30 +++
 rtl/tsmp_command_assemble_sat_counter.sv | 36 +++
 rtl/tsmp_command_assemble.sv | 161 ++++++++++++++++
 tb/tb_tsmp_command_assemble.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/tsn_cfg_pkg.sv
// Shared configuration-path definitions for the TSMP command assembler.
// Holds the command-word width, the command type codes, the field bit
// positions inside a command word and the assembler state encoding.
package tsn_cfg_pkg;

  localparam int unsigned CMD_W = 204;

  localparam logic [3:0] CMD_TYPE_WR    = 4'b0001;
  localparam logic [3:0] CMD_TYPE_RD    = 4'b0010;
  localparam logic [3:0] CMD_TYPE_RDACK = 4'b0110;

  localparam int unsigned RSV_MSB  = 203;
  localparam int unsigned RSV_LSB  = 196;
  localparam int unsigned MID_MSB  = 195;
  localparam int unsigned MID_LSB  = 188;
  localparam int unsigned TYPE_MSB = 187;
  localparam int unsigned TYPE_LSB = 184;
  localparam int unsigned ADDR_MSB = 183;
  localparam int unsigned ADDR_LSB = 152;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } asm_state_e;

  function automatic logic [3:0] cmd_type(input logic [CMD_W-1:0] word);
    return word[TYPE_MSB:TYPE_LSB];
  endfunction

endpackage

// File: rtl/tsmp_command_assemble_sat_counter.sv
// Saturating event counter.
// Ports:
//   i_clk   - clock
//   i_rst_n - synchronous active-low clear
//   i_inc   - count one event this cycle
//   ov_cnt  - current count, sticks at all-ones
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] ov_cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ov_cnt = cnt_q;

endmodule

// File: rtl/tsmp_command_assemble.sv
// TSMP configuration command assembler.
// Collects fixed-size commands from the NMAC payload byte stream of a
// decapsulated TSMP frame, steers completed words to the write or read
// command port by type, and keeps saturating statistics.
// Ports:
//   i_clk, i_rst_n        - clock, synchronous active-low reset
//   iv_pkt_data           - payload byte, MSB-first within a command
//   i_pkt_data_wr         - byte valid (gaps allowed)
//   i_pkt_head/i_pkt_tail - first/last byte of a frame, qualified by valid
//   ov_wr_command/_wr     - write command word and one-cycle strobe
//   ov_rd_command/_wr     - read command word and one-cycle strobe
//   ov_cmd_cnt            - commands delivered
//   ov_unknown_cnt        - complete commands dropped for unknown type
//   ov_err_cnt            - truncated or restarted commands
module tsmp_command_assemble
  import tsn_cfg_pkg::*;
#(
  parameter int unsigned CMD_BYTES = 26,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [7:0]       iv_pkt_data,
  input  logic             i_pkt_data_wr,
  input  logic             i_pkt_head,
  input  logic             i_pkt_tail,
  output logic [CMD_W-1:0] ov_wr_command,
  output logic             o_wr_command_wr,
  output logic [CMD_W-1:0] ov_rd_command,
  output logic             o_rd_command_wr,
  output logic [CNT_W-1:0] ov_cmd_cnt,
  output logic [CNT_W-1:0] ov_unknown_cnt,
  output logic [CNT_W-1:0] ov_err_cnt
);

  localparam int unsigned CW = $clog2(CMD_BYTES);
  localparam logic [CW-1:0] LAST_IDX = CW'(CMD_BYTES - 1);
  localparam int unsigned SR_W = CMD_W - 8;

  asm_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // Only the bits that can still reach the 204-bit word are kept; the
  // four leading bits of the first byte fall off the top when shifted.
  logic [SR_W-1:0]  sr_q, sr_d;
  logic [CMD_W-1:0] word;
  logic [CMD_W-1:0] wr_cmd_q, rd_cmd_q;
  logic             wr_stb_q, rd_stb_q;
  logic             done, err;
  logic             wr_hit, rd_hit, unk_hit;

  // Word as it stands once the current byte is shifted in.
  assign word = {sr_q, iv_pkt_data};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    done    = 1'b0;
    err     = 1'b0;
    if (i_pkt_data_wr) begin
      unique case (state_q)
        ST_IDLE: begin
          if (i_pkt_head) begin
            sr_d = word[SR_W-1:0];
            if (i_pkt_tail) begin
              err   = 1'b1;
              cnt_d = '0;
            end else begin
              cnt_d   = CW'(1);
              state_d = ST_COLLECT;
            end
          end
        end
        ST_COLLECT: begin
          sr_d = word[SR_W-1:0];
          if (i_pkt_head && (cnt_q != '0)) begin
            // Restart inside a command: the new byte becomes byte 1.
            err = 1'b1;
            if (i_pkt_tail) begin
              cnt_d   = '0;
              state_d = ST_IDLE;
            end else begin
              cnt_d = CW'(1);
            end
          end else if (cnt_q == LAST_IDX) begin
            done  = 1'b1;
            cnt_d = '0;
            if (i_pkt_tail) begin
              state_d = ST_IDLE;
            end
          end else if (i_pkt_tail) begin
            err     = 1'b1;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign wr_hit  = done && (cmd_type(word) == CMD_TYPE_WR);
  assign rd_hit  = done && (cmd_type(word) == CMD_TYPE_RD);
  assign unk_hit = done && !wr_hit && !rd_hit;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      sr_q     <= '0;
      wr_cmd_q <= '0;
      rd_cmd_q <= '0;
      wr_stb_q <= 1'b0;
      rd_stb_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      wr_stb_q <= wr_hit;
      rd_stb_q <= rd_hit;
      if (wr_hit) begin
        wr_cmd_q <= word;
      end
      if (rd_hit) begin
        rd_cmd_q <= word;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_cmd_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (wr_hit || rd_hit),
    .ov_cnt  (ov_cmd_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_unknown_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (unk_hit),
    .ov_cnt  (ov_unknown_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (err),
    .ov_cnt  (ov_err_cnt)
  );

  assign ov_wr_command   = wr_cmd_q;
  assign ov_rd_command   = rd_cmd_q;
  assign o_wr_command_wr = wr_stb_q;
  assign o_rd_command_wr = rd_stb_q;

endmodule

// File: tb/tb_tsmp_command_assemble.sv
module tb_tsmp_command_assemble;
  import tsn_cfg_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   data;
  logic         wr, head, tail;
  logic [203:0] wr_cmd, rd_cmd, s_wr_cmd, s_rd_cmd;
  logic         wr_stb, rd_stb, s_wr_stb, s_rd_stb;
  logic [15:0]  cmd_cnt, unk_cnt, err_cnt;
  logic [1:0]   s_cmd_cnt, s_unk_cnt, s_err_cnt;

  always #5 clk = ~clk;

  tsmp_command_assemble dut (
    .i_clk(clk), .i_rst_n(rst_n), .iv_pkt_data(data), .i_pkt_data_wr(wr),
    .i_pkt_head(head), .i_pkt_tail(tail),
    .ov_wr_command(wr_cmd), .o_wr_command_wr(wr_stb),
    .ov_rd_command(rd_cmd), .o_rd_command_wr(rd_stb),
    .ov_cmd_cnt(cmd_cnt), .ov_unknown_cnt(unk_cnt), .ov_err_cnt(err_cnt)
  );

  tsmp_command_assemble #(.CMD_BYTES(26), .CNT_W(2)) dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .iv_pkt_data(data), .i_pkt_data_wr(wr),
    .i_pkt_head(head), .i_pkt_tail(tail),
    .ov_wr_command(s_wr_cmd), .o_wr_command_wr(s_wr_stb),
    .ov_rd_command(s_rd_cmd), .o_rd_command_wr(s_rd_stb),
    .ov_cmd_cnt(s_cmd_cnt), .ov_unknown_cnt(s_unk_cnt), .ov_err_cnt(s_err_cnt)
  );

  typedef struct {
    logic         is_rd;
    logic [203:0] word;
    int unsigned  cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          tests = 0;
  int          fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [203:0] act, input logic [203:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes.
  always @(negedge clk) begin
    exp_t e;
    if (wr_stb || rd_stb) begin
      check("dual_strobe", 204'(wr_stb && rd_stb), 204'(0));
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_strobe: got wr=%0b rd=%0b at cycle %0d expected none", wr_stb, rd_stb, cyc);
      end else begin
        e = sb.pop_front();
        check("strobe_port", 204'(rd_stb), 204'(e.is_rd));
        check("strobe_cycle", 204'(cyc), 204'(e.cyc));
        check("cmd_word", e.is_rd ? rd_cmd : wr_cmd, e.word);
        check("sat_strobe", 204'({s_rd_stb, s_wr_stb}), e.is_rd ? 204'(2) : 204'(1));
        check("sat_word", e.is_rd ? s_rd_cmd : s_wr_cmd, e.word);
      end
    end
  end

  function automatic logic [207:0] mk(input logic [3:0] junk, input logic [7:0] rsv,
                                      input logic [7:0] mid, input logic [3:0] typ,
                                      input logic [31:0] addr, input logic [151:0] d);
    return {junk, rsv, mid, typ, addr, d};
  endfunction

  task automatic put(input logic [7:0] b, input logic h, input logic t);
    data = b; wr = 1'b1; head = h; tail = t;
    @(negedge clk);
    wr = 1'b0; head = 1'b0; tail = 1'b0;
  endtask

  // Sends bytes 0..n-1 of a command; expects a strobe only for a full
  // command of write or read type.
  task automatic send_cmd(input logic [207:0] c, input int n, input logic h,
                          input logic t, input int gap);
    exp_t e;
    logic [3:0] typ;
    typ = c[187:184];
    for (int i = 0; i < n; i++) begin
      if (i == 25 && (typ == CMD_TYPE_WR || typ == CMD_TYPE_RD)) begin
        e.is_rd = (typ == CMD_TYPE_RD);
        e.word  = c[203:0];
        e.cyc   = cyc + 1;
        sb.push_back(e);
      end
      put(c[207-8*i -: 8], h && (i == 0), t && (i == n - 1));
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge clk);
    check("drain", 204'(sb.size()), 204'(0));
    repeat (3) @(negedge clk);
  endtask

  task automatic check_cnts(input string tag, input int c, input int u, input int e);
    check({tag, "_cmd_cnt"}, 204'(cmd_cnt), 204'(c));
    check({tag, "_unknown_cnt"}, 204'(unk_cnt), 204'(u));
    check({tag, "_err_cnt"}, 204'(err_cnt), 204'(e));
  endtask

  logic [207:0] c1, c2a, c2b, c2c, c4, c5, c6;

  initial begin
    c1  = mk(4'hA, 8'h5A, 8'h0D, CMD_TYPE_WR, 32'h5, 152'h1234_5678_9ABC);
    c2a = mk(4'h0, 8'h11, 8'h20, CMD_TYPE_WR, 32'h100, 152'hCAFE);
    c2b = mk(4'h0, 8'h00, 8'h21, CMD_TYPE_RD, 32'hC, 152'h0);
    c2c = mk(4'h3, 8'hFF, 8'h22, CMD_TYPE_WR, 32'hFFFF_FFFF, {152{1'b1}});
    c4  = mk(4'h0, 8'h33, 8'h44, CMD_TYPE_RD, 32'hDEAD, 152'h77);
    c5  = mk(4'hF, 8'h81, 8'h55, CMD_TYPE_WR, 32'h8000_0001, 152'hA5A5);
    c6  = mk(4'h0, 8'h00, 8'h66, CMD_TYPE_RDACK, 32'h42, 152'h1);

    rst_n = 1'b0; data = '0; wr = 1'b0; head = 1'b0; tail = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_wr_cmd", wr_cmd, '0);
    check("rst_rd_cmd", rd_cmd, '0);
    check("rst_strobes", 204'({wr_stb, rd_stb}), 204'(0));
    check_cnts("rst", 0, 0, 0);

    // Single write command in one frame.
    send_cmd(c1, 26, 1'b1, 1'b1, 0);
    drain();
    check("t1_mid", 204'(wr_cmd[195:188]), 204'(8'h0D));
    check("t1_type", 204'(wr_cmd[187:184]), 204'(4'b0001));
    check("t1_addr", 204'(wr_cmd[183:152]), 204'(32'h5));
    check("t1_rsv", 204'(wr_cmd[203:196]), 204'(8'h5A));
    check_cnts("t1", 1, 0, 0);

    // Three back-to-back commands; head on the second at a command boundary.
    send_cmd(c2a, 26, 1'b1, 1'b0, 0);
    send_cmd(c2b, 26, 1'b1, 1'b0, 0);
    send_cmd(c2c, 26, 1'b0, 1'b1, 0);
    drain();
    check("t2_rd_type", 204'(rd_cmd[187:184]), 204'(4'b0010));
    check("t2_rd_addr", 204'(rd_cmd[183:152]), 204'(32'hC));
    check_cnts("t2", 4, 0, 0);

    // Gapped byte valid.
    send_cmd(c1, 26, 1'b1, 1'b1, 2);
    drain();
    check("t3_rd_hold", rd_cmd, c2b[203:0]);
    check_cnts("t3", 5, 0, 0);

    // Tail on byte 10, then a good frame.
    send_cmd(c2a, 10, 1'b1, 1'b1, 0);
    send_cmd(c4, 26, 1'b1, 1'b1, 0);
    drain();
    check("t4_wr_hold", wr_cmd, c1[203:0]);
    check_cnts("t4", 6, 0, 1);

    // Head at byte 15 restarts a command.
    send_cmd(c2c, 14, 1'b1, 1'b0, 1);
    send_cmd(c5, 26, 1'b1, 1'b1, 0);
    drain();
    check_cnts("t5", 7, 0, 2);

    // Unknown type, then a single-byte frame.
    send_cmd(c6, 26, 1'b1, 1'b1, 0);
    send_cmd(c1, 1, 1'b1, 1'b1, 0);
    drain();
    check_cnts("t6", 7, 1, 3);
    check("sat_cmd_cnt", 204'(s_cmd_cnt), 204'(3));
    check("sat_unknown_cnt", 204'(s_unk_cnt), 204'(1));
    check("sat_err_cnt", 204'(s_err_cnt), 204'(3));

    // Reset asserted with byte 12 of a command.
    send_cmd(c2a, 11, 1'b1, 1'b0, 0);
    rst_n = 1'b0;
    put(c2a[207-8*11 -: 8], 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check_cnts("rst2", 0, 0, 0);
    check("rst2_wr_cmd", wr_cmd, '0);
    check("rst2_rd_cmd", rd_cmd, '0);
    check("rst2_sat_cmd_cnt", 204'(s_cmd_cnt), 204'(0));

    send_cmd(c4, 26, 1'b1, 1'b1, 0);
    drain();
    check_cnts("post_rst", 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
